eth_decap: RTL and testbench

- Receive-side counterpart of the TLP-over-Ethernet encapsulator.
- Consumes frames from the 10G MAC RX AXI-Stream in the clk156 domain.
- Filters on EtherType, strips the 14-byte Ethernet header, and realigns the payload to 8-byte words.
- Writes payload beats into the eth2pcie FIFO (74-bit entries), which feeds the PCIe-side TLP injector.

---
 rtl/eth_decap.sv | 216 +++++++++++++++++++++
 tb/tb_eth_decap.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_decap.sv
// Ethernet RX decapsulator: EtherType filter, 14-byte header strip, 8-byte payload realign into eth2pcie FIFO.
// Define ETH_DECAP_STATS_EN to build the frame statistics counters; otherwise the stat outputs read 0.
module eth_decap #(
  parameter logic [15:0] ETHERTYPE  = 16'h3776,
  parameter int          DATA_WIDTH = 64,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk156,
  input  logic                  sys_rst,
  input  logic                  s_axis_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  output logic                  wr_en,
  output logic [73:0]           din,
  input  logic                  full,
  output logic [31:0]           stat_frames_ok,
  output logic [31:0]           stat_frames_type,
  output logic [31:0]           stat_frames_ovf
);

  localparam logic [2:0] HDR0    = 3'd0;
  localparam logic [2:0] HDR1    = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;
  localparam logic [2:0] DROP    = 3'd5;
  localparam logic [2:0] TERM    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  hold_keep_q, hold_keep_d;
  logic        err_lat_q, err_lat_d;
  logic        inprog_q, inprog_d;
  logic        disc_type_q, disc_type_d;
  logic        wr_en_q, wr_en_d;
  logic [73:0] din_q, din_d;
  logic        ev_ok, ev_type, ev_ovf;

  logic [15:0] etype;
  logic [63:0] rw_data;
  logic [7:0]  rw_keep;
  logic        final_now;
  logic        inprog_nxt;

  assign etype      = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
  assign rw_data    = {s_axis_rx_tdata[47:0], hold_q};
  assign rw_keep    = {s_axis_rx_tkeep[5:0], hold_keep_q};
  assign final_now  = s_axis_rx_tlast && (s_axis_rx_tkeep[7:6] == 2'b00);
  assign inprog_nxt = s_axis_rx_tvalid ? ~s_axis_rx_tlast : inprog_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stage p0: decode the incoming beat and form the FIFO entry
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_keep_d = hold_keep_q;
    err_lat_d   = err_lat_q;
    inprog_d    = inprog_q;
    disc_type_d = disc_type_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    ev_ok       = 1'b0;
    ev_type     = 1'b0;
    ev_ovf      = 1'b0;
    case (state_q)
      HDR0: begin
        if (s_axis_rx_tvalid) begin
          if (s_axis_rx_tlast) ev_type = 1'b1;
          else                 state_d = HDR1;
        end
      end
      HDR1: begin
        if (s_axis_rx_tvalid) begin
          hold_d      = s_axis_rx_tdata[63:48];
          hold_keep_d = s_axis_rx_tkeep[7:6];
          if (s_axis_rx_tlast) begin
            ev_type = 1'b1;
            state_d = HDR0;
          end else if (etype != ETHERTYPE) begin
            disc_type_d = 1'b1;
            state_d     = DISCARD;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (s_axis_rx_tvalid) begin
          hold_d      = s_axis_rx_tdata[63:48];
          hold_keep_d = s_axis_rx_tkeep[7:6];
          if (full) begin
            inprog_d = 1'b0;
            state_d  = s_axis_rx_tlast ? TERM : DROP;
          end else begin
            wr_en_d = 1'b1;
            din_d   = {final_now & ~s_axis_rx_tuser, final_now, rw_keep, rw_data};
            if (final_now) begin
              ev_ok   = s_axis_rx_tuser;
              state_d = HDR0;
            end else if (s_axis_rx_tlast) begin
              err_lat_d = ~s_axis_rx_tuser;
              state_d   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (full) begin
          inprog_d = s_axis_rx_tvalid & ~s_axis_rx_tlast;
          state_d  = TERM;
        end else begin
          wr_en_d = 1'b1;
          din_d   = {err_lat_q, 1'b1, 6'b0, hold_keep_q, 48'b0, hold_q};
          ev_ok   = ~err_lat_q;
          state_d = HDR0;
          // The next frame's first header beat may already be here
          if (s_axis_rx_tvalid) begin
            if (s_axis_rx_tlast) ev_type = 1'b1;
            else                 state_d = HDR1;
          end
        end
      end
      DISCARD: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          ev_type     = disc_type_q;
          disc_type_d = 1'b0;
          state_d     = HDR0;
        end
      end
      DROP: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          inprog_d = 1'b0;
          state_d  = TERM;
        end
      end
      TERM: begin
        inprog_d = inprog_nxt;
        if (!full) begin
          wr_en_d     = 1'b1;
          din_d       = {1'b1, 1'b1, 8'h00, 64'h0};
          ev_ovf      = 1'b1;
          disc_type_d = 1'b0;
          inprog_d    = 1'b0;
          state_d     = inprog_nxt ? DISCARD : HDR0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // Stage p1: registered FIFO write and FSM state
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q     <= HDR0;
      hold_q      <= 16'h0;
      hold_keep_q <= 2'b00;
      err_lat_q   <= 1'b0;
      inprog_q    <= 1'b0;
      disc_type_q <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= 74'h0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_keep_q <= hold_keep_d;
      err_lat_q   <= err_lat_d;
      inprog_q    <= inprog_d;
      disc_type_q <= disc_type_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
    end
  end

  assign wr_en = wr_en_q;
  assign din   = din_q;

`ifdef ETH_DECAP_STATS_EN
  logic [31:0] cnt_ok_q, cnt_ok_d;
  logic [31:0] cnt_type_q, cnt_type_d;
  logic [31:0] cnt_ovf_q, cnt_ovf_d;

  always_comb begin
    cnt_ok_d   = ev_ok   ? sat_inc(cnt_ok_q)   : cnt_ok_q;
    cnt_type_d = ev_type ? sat_inc(cnt_type_q) : cnt_type_q;
    cnt_ovf_d  = ev_ovf  ? sat_inc(cnt_ovf_q)  : cnt_ovf_q;
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      cnt_ok_q   <= 32'h0;
      cnt_type_q <= 32'h0;
      cnt_ovf_q  <= 32'h0;
    end else begin
      cnt_ok_q   <= cnt_ok_d;
      cnt_type_q <= cnt_type_d;
      cnt_ovf_q  <= cnt_ovf_d;
    end
  end

  assign stat_frames_ok   = cnt_ok_q;
  assign stat_frames_type = cnt_type_q;
  assign stat_frames_ovf  = cnt_ovf_q;
`else
  logic [31:0] unused_stats;
  assign unused_stats     = sat_inc({29'h0, ev_ok, ev_type, ev_ovf});
  assign stat_frames_ok   = 32'h0;
  assign stat_frames_type = 32'h0;
  assign stat_frames_ovf  = 32'h0;
`endif

endmodule

// File: tb/tb_eth_decap.sv
// Scoreboard bench for eth_decap: directed frames push expected FIFO entries; a monitor pops on wr_en.
module tb_eth_decap;
  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        s_axis_rx_tvalid;
  logic [63:0] s_axis_rx_tdata;
  logic [7:0]  s_axis_rx_tkeep;
  logic        s_axis_rx_tlast;
  logic        s_axis_rx_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic [31:0] stat_frames_ok;
  logic [31:0] stat_frames_type;
  logic [31:0] stat_frames_ovf;

  eth_decap dut (
    .clk156           (clk156),
    .sys_rst          (sys_rst),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tuser  (s_axis_rx_tuser),
    .wr_en            (wr_en),
    .din              (din),
    .full             (full),
    .stat_frames_ok   (stat_frames_ok),
    .stat_frames_type (stat_frames_type),
    .stat_frames_ovf  (stat_frames_ovf)
  );

  always #5 clk156 = ~clk156;

  logic [73:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [73:0] got, input logic [73:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // Frame byte i: MACs A0.., EtherType big-endian, then payload byte j = j
  function automatic logic [7:0] fbyte(input int i, input logic [15:0] et);
    logic [31:0] v;
    v = i - 14;
    if (i < 12)       return 8'hA0 + 8'(i);
    else if (i == 12) return et[15:8];
    else if (i == 13) return et[7:0];
    else              return v[7:0];
  endfunction

  // Payload as 8-byte chunks; final chunk carries last and the error flag
  task automatic push_exp(input int n, input logic tu);
    int p, nw, idx;
    logic [63:0] d;
    logic [7:0]  k;
    logic        lst;
    p  = n - 14;
    nw = (p + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d = 64'h0;
      k = 8'h0;
      for (int b = 0; b < 8; b++) begin
        idx = w * 8 + b;
        if (idx < p) begin
          d[b*8 +: 8] = 8'(idx);
          k[b]        = 1'b1;
        end
      end
      lst = (w == nw - 1);
      exp_q.push_back({lst & ~tu, lst, k, d});
    end
  endtask

  task automatic send(input logic [15:0] et, input int n, input logic tu,
                      input int fs, input int fl);
    int nb, nc, i;
    nb = (n + 7) / 8;
    nc = nb;
    if (fs >= 0 && fs + fl > nc) nc = fs + fl;
    for (int c = 0; c < nc; c++) begin
      @(posedge clk156);
      #1;
      full = (fs >= 0) && (c >= fs) && (c < fs + fl);
      if (c < nb) begin
        s_axis_rx_tvalid = 1'b1;
        s_axis_rx_tdata  = 64'h0;
        s_axis_rx_tkeep  = 8'h0;
        for (int b = 0; b < 8; b++) begin
          i = c * 8 + b;
          if (i < n) begin
            s_axis_rx_tdata[b*8 +: 8] = fbyte(i, et);
            s_axis_rx_tkeep[b]        = 1'b1;
          end
        end
        s_axis_rx_tlast = (c == nb - 1);
        s_axis_rx_tuser = tu;
      end else begin
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tlast  = 1'b0;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      @(posedge clk156);
      #1;
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tlast  = 1'b0;
      full             = 1'b0;
    end
  endtask

  always @(negedge clk156) begin
    if (!sys_rst && wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", din, 74'h0 ^ {74{1'b1}} ^ din ^ din);
      else chk("fifo_entry", din, exp_q.pop_front());
    end
  end

  initial begin
    sys_rst          = 1'b1;
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tdata  = 64'h0;
    s_axis_rx_tkeep  = 8'h0;
    s_axis_rx_tlast  = 1'b0;
    s_axis_rx_tuser  = 1'b0;
    full             = 1'b0;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    chk("rst_wr_en", {73'h0, wr_en}, 74'h0);
    chk("rst_din", din, 74'h0);
    chk("rst_stats", {42'h0, stat_frames_ok | stat_frames_type | stat_frames_ovf}, 74'h0);
    @(posedge clk156);
    #1 sys_rst = 1'b0;
    idle(2);

    // 64-byte frame: 7 writes, first 0706050403020100, flush keep 03
    exp_q.push_back({2'b00, 8'hFF, 64'h0706_0504_0302_0100});
    push_exp(64, 1'b1);
    void'(exp_q.pop_back());
    exp_q.push_back({2'b01, 8'h03, 64'h0000_0000_0000_3130});
    begin
      logic [73:0] first;
      first = exp_q[0];
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_front(first);
    end
    send(16'h3776, 64, 1'b1, -1, 0);
    idle(3);

    send(16'h0800, 64, 1'b1, -1, 0);
    idle(3);

    // 24-byte payload, final beat keep 3F: last word keep FF, no flush
    push_exp(38, 1'b1);
    send(16'h3776, 38, 1'b1, -1, 0);
    idle(3);

    // flush cycle overlaps the next frame's first beat
    push_exp(64, 1'b1);
    push_exp(30, 1'b1);
    send(16'h3776, 64, 1'b1, -1, 0);
    send(16'h3776, 30, 1'b1, -1, 0);
    idle(3);

    send(16'h3776, 8, 1'b1, -1, 0);
    idle(2);
    send(16'h3776, 14, 1'b1, -1, 0);
    idle(2);

    push_exp(64, 1'b0);
    send(16'h3776, 64, 1'b0, -1, 0);
    idle(3);

    // full on third payload beat for 5 cycles: two writes then terminator
    exp_q.push_back({2'b00, 8'hFF, 64'h0706_0504_0302_0100});
    exp_q.push_back({2'b00, 8'hFF, 64'h0F0E_0D0C_0B0A_0908});
    exp_q.push_back({2'b11, 8'h00, 64'h0});
    send(16'h3776, 64, 1'b1, 4, 5);
    idle(4);

    push_exp(50, 1'b1);
    send(16'h3776, 50, 1'b1, -1, 0);
    idle(20);

    @(negedge clk156);
    chk("queue_drained", 74'(exp_q.size()), 74'h0);
`ifdef ETH_DECAP_STATS_EN
    chk("stat_ok",   {42'h0, stat_frames_ok},   74'd5);
    chk("stat_type", {42'h0, stat_frames_type}, 74'd3);
    chk("stat_ovf",  {42'h0, stat_frames_ovf},  74'd1);
`else
    chk("stat_ok",   {42'h0, stat_frames_ok},   74'd0);
    chk("stat_type", {42'h0, stat_frames_type}, 74'd0);
    chk("stat_ovf",  {42'h0, stat_frames_ovf},  74'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
